// File: rtl/ifetch_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch memory responder: base address,
// FSM state encoding and the address decode helpers used by the read and write paths.
package ifetch_mem_responder_pkg;

    localparam logic [31:0] MEM_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the byte address falls inside the array window starting at base.
    // The subtraction wraps, so addresses below base land far out of range.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth_log2);
        logic [31:0] off;
        off = addr - base;
        return ({1'b0, off} < (33'd8 << depth_log2));
    endfunction

    // Doubleword number relative to base; callers keep only the low index bits.
    function automatic logic [28:0] addr_dword(input logic [31:0] addr,
                                               input logic [31:0] base);
        return 29'((addr - base) >> 3);
    endfunction

endpackage

// File: rtl/ifetch_mem_responder_mem_dword_array.sv
// Doubleword storage split into eight byte lanes so each strobe maps onto its own
// narrow RAM. Writes and reads share one edge; a read on the edge of a write to
// the same index returns the previous contents.
module ifetch_mem_responder_mem_dword_array
    import ifetch_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [63:0]           wr_data,
    input  logic [7:0]            wr_strb,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [63:0]           rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            // Byte-lane write under its strobe, and registered read that sees the old value on a collision.
            always_ff @(posedge clk) begin
                if (wr_en && wr_strb[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    lane_q_reg <= lane_mem[rd_idx];
                end
            end

            assign rd_data[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/ifetch_mem_responder.sv
// Memory-side responder for instruction fetch and loads: one outstanding aligned
// 64-bit read at a time, fixed LATENCY (1..15) from accept to response, with an
// independent byte-strobed write port into the same array.
module ifetch_mem_responder
    import ifetch_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = MEM_BASE,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         SINGLE   = (LATENCY == 1);

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic [DEPTH_LOG2-1:0] idx_reg;
    logic                  in_range_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;

    logic [28:0]           req_dword;
    logic [28:0]           wr_dword;
    logic                  req_in_range;
    logic                  wr_in_range;
    logic                  accept;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [63:0]           rd_data;
    logic                  wr_go;
    logic                  unused_dword_bits;

    assign req_in_range = addr_in_range(req_addr, BASE, DEPTH_LOG2);
    assign req_dword    = addr_dword(req_addr, BASE);
    assign wr_in_range  = addr_in_range(wr_addr, BASE, DEPTH_LOG2);
    assign wr_dword     = addr_dword(wr_addr, BASE);

    // Only the low index bits address the array; the rest is covered by the range flag.
    assign unused_dword_bits = ^{req_dword, wr_dword};

    assign req_ready = (state_reg == IDLE) && !rst;
    assign accept    = req_ready && req_valid;

    // The array read is launched on the edge that enters RESP, so its output
    // register already holds the response data when rsp_valid rises.
    assign rd_en  = SINGLE ? accept : ((state_reg == WAIT) && (cnt_reg == 4'd1));
    assign rd_idx = (state_reg == IDLE) ? req_dword[DEPTH_LOG2-1:0] : idx_reg;

    // Writes are dropped during reset and when they miss the array window.
    assign wr_go = wr_en && !rst && wr_in_range;

    ifetch_mem_responder_mem_dword_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_go),
        .wr_idx (wr_dword[DEPTH_LOG2-1:0]),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    // Request/response sequencing: accept in IDLE, count down in WAIT, hold in RESP until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            idx_reg       <= '0;
            in_range_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        idx_reg      <= req_dword[DEPTH_LOG2-1:0];
                        in_range_reg <= req_in_range;
                        cnt_reg      <= CNT_LOAD;
                        if (SINGLE) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= !req_in_range;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd1) begin
                        state_reg     <= RESP;
                        cnt_reg       <= 4'd0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= !in_range_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Data is forced to zero outside a good response, which also covers error responses and reset.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_data  = (rsp_valid_reg && !rsp_err_reg) ? rd_data : 64'd0;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Bench for ifetch_mem_responder: two instances (LATENCY=1 and LATENCY=4) share
// the write port and reset; a word-level memory model predicts every read.
module tb_ifetch_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch_mem_responder #(.DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    ifetch_mem_responder #(.DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(4)) dut_lat4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- reference model: 32 KiB window of doublewords ----------------
    logic [63:0] ref_mem [int unsigned];

    function automatic bit model_hit(input logic [31:0] a);
        longint unsigned x;
        x = {32'd0, a};
        return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 64'd32768);
    endfunction

    function automatic int unsigned model_idx(input logic [31:0] a);
        return int'((a - 32'h8000_0000) / 8);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] cur;
        int unsigned idx;
        if (!model_hit(a)) return;
        idx = model_idx(a);
        cur = ref_mem.exists(idx) ? ref_mem[idx] : 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        end
        ref_mem[idx] = cur;
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [63:0] d, output logic e);
        if (model_hit(a)) begin
            d = ref_mem.exists(model_idx(a)) ? ref_mem[model_idx(a)] : 64'hx;
            e = 1'b0;
        end else begin
            d = 64'd0;
            e = 1'b1;
        end
    endfunction

    function automatic logic [31:0] pick_addr();
        int sel;
        logic [31:0] lo;
        sel = $urandom_range(0, 9);
        lo  = 32'($urandom_range(0, 7));
        if (sel < 8) return 32'h8000_0000 + 32'($urandom_range(0, 31)) * 8 + lo;
        if (sel == 8) return 32'h8000_8000 + 32'($urandom_range(0, 31)) * 8 + lo;
        return 32'h8000_0000 - 32'($urandom_range(1, 32)) * 8 + lo;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_write(a, d, s);
    endtask

    // One full read: request, wait for response, optionally stall, then handshake.
    task automatic read_txn(input int k, input logic [31:0] addr, input int hold,
                            output logic [63:0] data, output logic err, output int lat);
        int   w;
        logic busy_ready;
        logic held_ok;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        w = 0;
        while (!req_ready[k] && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 64'(w < 64), 64'd1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom();
        lat = 0;
        busy_ready = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            busy_ready |= req_ready[k];
        end while (!rsp_valid[k] && lat < 40);
        data = rsp_data[k];
        err  = rsp_err[k];
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            @(negedge clk);
            if (!rsp_valid[k] || req_ready[k] || rsp_data[k] !== data || rsp_err[k] !== err) held_ok = 1'b0;
        end
        chk("busy_req_ready", 64'(busy_ready), 64'd0);
        chk("hold_stable", 64'(held_ok), 64'd1);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[k] = 1'b0;
        req_valid[k] = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop", 64'(rsp_valid[k]), 64'd0);
        $display("txn dut%0d addr=%h hold=%0d data=%h err=%b lat=%0d", k, addr, hold, data, err, lat);
    endtask

    typedef struct {
        int          k;
        logic [31:0] addr;
        int          hold;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [63:0] d;
        logic [63:0] md;
        logic        e;
        logic        me;
        int          lat;
        logic        saw;

        vecs[0] = '{0, 32'h8000_0004, 0, 64'h0000_0013_0010_0093, 1'b0, 1};
        vecs[1] = '{1, 32'h8000_0008, 3, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 4};
        vecs[2] = '{0, 32'h7FFF_FFF8, 0, 64'd0,                   1'b1, 1};
        vecs[3] = '{1, 32'h8000_8000, 1, 64'd0,                   1'b1, 4};
        vecs[4] = '{0, 32'h8000_0010, 2, 64'h1111_2222_CCCC_DDDD, 1'b0, 1};
        vecs[5] = '{1, 32'h8000_7FFF, 0, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0, 4};
        vecs[6] = '{1, 32'h8000_0000, 0, 64'h0000_0013_0010_0093, 1'b0, 4};
        vecs[7] = '{0, 32'hFFFF_FFF8, 0, 64'd0,                   1'b1, 1};

        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b0;
        end

        // reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_req_ready%0d", k), 64'(req_ready[k]), 64'd0);
            chk($sformatf("reset_rsp_valid%0d", k), 64'(rsp_valid[k]), 64'd0);
            chk($sformatf("reset_rsp_data%0d", k), rsp_data[k], 64'd0);
            chk($sformatf("reset_rsp_err%0d", k), 64'(rsp_err[k]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready0", 64'(req_ready[0]), 64'd1);
        chk("idle_req_ready1", 64'(req_ready[1]), 64'd1);

        // preload, including out-of-range writes that would alias words 0 and 4095
        mem_write(32'h8000_0000, 64'h0000_0013_0010_0093, 8'hFF);
        mem_write(32'h8000_0008, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        mem_write(32'h8000_0010, 64'h1111_2222_3333_4444, 8'hFF);
        mem_write(32'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        mem_write(32'h8000_7FF8, 64'h5A5A_A5A5_0F0F_F0F0, 8'hFF);
        mem_write(32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        mem_write(32'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            read_txn(vecs[i].k, vecs[i].addr, vecs[i].hold, d, e, lat);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // collision: write on the RESP-entry edge returns old data, re-read returns new
        mem_write(32'h8000_0018, 64'h0102_0304_0506_0708, 8'hFF);
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0018;
        wr_en = 1'b1; wr_addr = 32'h8000_0018; wr_data = 64'hCAFE_F00D_1234_5678; wr_strb = 8'hFF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0; wr_en = 1'b0;
        model_write(32'h8000_0018, 64'hCAFE_F00D_1234_5678, 8'hFF);
        @(negedge clk);
        chk("coll_rsp_valid", 64'(rsp_valid[0]), 64'd1);
        chk("coll_old_data", rsp_data[0], 64'h0102_0304_0506_0708);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        read_txn(0, 32'h8000_0018, 0, d, e, lat);
        chk("coll_new_data", d, 64'hCAFE_F00D_1234_5678);

        // request held high across a response is taken in the first IDLE cycle
        mem_write(32'h8000_0028, 64'h2828_2828_2828_2828, 8'hFF);
        mem_write(32'h8000_0030, 64'h3030_3030_3030_3030, 8'hFF);
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0028;
        @(posedge clk);
        #1;
        req_addr[0] = 32'h8000_0030;
        @(negedge clk);
        chk("held_first_data", rsp_data[0], 64'h2828_2828_2828_2828);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        chk("held_gap_valid", 64'(rsp_valid[0]), 64'd0);
        chk("held_gap_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("held_second_valid", 64'(rsp_valid[0]), 64'd1);
        chk("held_second_data", rsp_data[0], 64'h3030_3030_3030_3030);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;

        // reset during WAIT drops the request; a write during reset is ignored
        mem_write(32'h8000_0020, 64'h7777_6666_5555_4444, 8'hFF);
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0000;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h8000_0020; wr_data = 64'hBAD0_BAD0_BAD0_BAD0; wr_strb = 8'hFF;
        #1;
        chk("rst_req_ready0", 64'(req_ready[0]), 64'd0);
        chk("rst_req_ready1", 64'(req_ready[1]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("post_rst_data", rsp_data[1], 64'd0);
        chk("post_rst_err", 64'(rsp_err[1]), 64'd0);
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid[1]) saw = 1'b1;
            @(negedge clk);
        end
        chk("dropped_no_rsp", 64'(saw), 64'd0);
        read_txn(1, 32'h8000_0020, 0, d, e, lat);
        chk("post_rst_read", d, 64'h7777_6666_5555_4444);
        chk("post_rst_lat", 64'(lat), 64'd4);

        // randomized traffic against the model
        for (int w = 0; w < 32; w++) begin
            mem_write(32'h8000_0000 + 32'(w) * 8, {$urandom(), $urandom()}, 8'hFF);
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_write(pick_addr(), {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
            end else begin
                int          k;
                logic [31:0] a;
                k = $urandom_range(0, 1);
                a = pick_addr();
                model_read(a, md, me);
                read_txn(k, a, $urandom_range(0, 2), d, e, lat);
                chk($sformatf("rnd%0d_data", i), d, md);
                chk($sformatf("rnd%0d_err", i), 64'(e), 64'(me));
                chk($sformatf("rnd%0d_lat", i), 64'(lat), (k == 1) ? 64'd4 : 64'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
